rate_gen: RTL and testbench

Parametrised multi-channel rate generator for the Genius game timing path. It derives NCH independent, runtime-programmable periodic tick strobes (and optional square waves) from the system clock. Game LED/sound pacing and difficulty levels consume these strobes as clock enables. It replaces fixed-divisor clock outputs with a per-channel divisor register, enables, and global phase alignment.

---
 rtl/rate_gen_pkg.sv | 29 ++
 rtl/rate_gen_ch.sv | 72 +++++++
 rtl/rate_gen.sv | 44 ++++
 tb/tb_rate_gen.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rate_gen_pkg.sv
// Shared constants for the rate generator: default counter width, system clock
// rate and the divisors that pace the Genius difficulty levels.
package rate_gen_pkg;

    localparam int RG_CNT_W  = 28;
    localparam int RG_CLK_HZ = 50_000_000;

    localparam logic [RG_CNT_W-1:0] RG_DIV_1HZ = 28'd50_000_000;
    localparam logic [RG_CNT_W-1:0] RG_DIV_2HZ = 28'd25_000_000;
    localparam logic [RG_CNT_W-1:0] RG_DIV_3HZ = 28'd16_666_667;
    localparam logic [RG_CNT_W-1:0] RG_DIV_5HZ = 28'd10_000_000;

    typedef enum logic [1:0] {
        LVL_1HZ,
        LVL_2HZ,
        LVL_3HZ,
        LVL_5HZ
    } level_e;

    function automatic logic [RG_CNT_W-1:0] level_div(input level_e lvl);
        case (lvl)
            LVL_1HZ: level_div = RG_DIV_1HZ;
            LVL_2HZ: level_div = RG_DIV_2HZ;
            LVL_3HZ: level_div = RG_DIV_3HZ;
            default: level_div = RG_DIV_5HZ;
        endcase
    endfunction

endpackage

// File: rtl/rate_gen_ch.sv
// One rate channel: counter, active/pending divisor, busy flag, tick strobe and,
// with RATE_GEN_SQUARE_EN defined, a square-wave flop toggled on every wrap.
module rate_gen_ch
    import rate_gen_pkg::*;
#(
    parameter int               CNT_W    = RG_CNT_W,
    parameter logic [CNT_W-1:0] DIV_INIT = CNT_W'(50)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             sync_i,
    input  logic             wr_i,
    input  logic [CNT_W-1:0] data_i,
    output logic             busy_o,
    output logic             tick_o,
    output logic             sq_o
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] act;
    logic [CNT_W-1:0] pend;
    logic [CNT_W-1:0] last;
    logic             wrap;
    logic             load;

    // A divisor of 0 behaves as 1, so the terminal count saturates at 0.
    assign last = (act == '0) ? '0 : act - CNT_W'(1);
    assign wrap = en_i && (cnt == last);
    // pend mirrors act whenever busy is low, so loading pend is always safe.
    assign load = sync_i || wrap || !en_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt    <= '0;
            act    <= DIV_INIT;
            pend   <= DIV_INIT;
            busy_o <= 1'b0;
            tick_o <= 1'b0;
        end else begin
            tick_o <= wrap && !sync_i;

            if (sync_i || wrap)
                cnt <= '0;
            else if (en_i)
                cnt <= cnt + CNT_W'(1);

            if (load) begin
                act    <= wr_i ? data_i : pend;
                pend   <= wr_i ? data_i : pend;
                busy_o <= 1'b0;
            end else if (wr_i) begin
                pend   <= data_i;
                busy_o <= 1'b1;
            end
        end
    end

`ifdef RATE_GEN_SQUARE_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            sq_o <= 1'b0;
        else if (sync_i)
            sq_o <= 1'b0;
        else if (wrap)
            sq_o <= ~sq_o;
    end
`else
    assign sq_o = 1'b0;
`endif

endmodule

// File: rtl/rate_gen.sv
// Multi-channel programmable tick generator; square-wave outputs are built only
// when RATE_GEN_SQUARE_EN is defined, otherwise sq_o is tied low.
module rate_gen
    import rate_gen_pkg::*;
#(
    parameter int                     NCH      = 4,
    parameter int                     CNT_W    = RG_CNT_W,
    parameter logic [NCH*CNT_W-1:0]   DIV_INIT = {NCH{CNT_W'(50)}},
    parameter int                     SEL_W    = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [NCH-1:0]   en_i,
    input  logic             sync_i,
    input  logic             div_wr_i,
    input  logic [SEL_W-1:0] div_sel_i,
    input  logic [CNT_W-1:0] div_data_i,
    output logic [NCH-1:0]   div_busy_o,
    output logic [NCH-1:0]   tick_o,
    output logic [NCH-1:0]   sq_o
);

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        // Selects at or beyond NCH match no channel and are dropped here.
        logic wr_k;
        assign wr_k = div_wr_i && (32'(div_sel_i) == k);

        rate_gen_ch #(
            .CNT_W    (CNT_W),
            .DIV_INIT (DIV_INIT[k*CNT_W +: CNT_W])
        ) u_ch (
            .clk_i  (clk_i),
            .rst_i  (rst_i),
            .en_i   (en_i[k]),
            .sync_i (sync_i),
            .wr_i   (wr_k),
            .data_i (div_data_i),
            .busy_o (div_busy_o[k]),
            .tick_o (tick_o[k]),
            .sq_o   (sq_o[k])
        );
    end

endmodule

// File: tb/tb_rate_gen.sv
// Directed bench for rate_gen: vector table for the reset-divisor pattern plus
// hand-written sequences for divisor updates, disable, sync and reset.
module tb_rate_gen;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic [3:0] en_i;
    logic       sync_i;
    logic       div_wr_i;
    logic [2:0] div_sel_i;
    logic [7:0] div_data_i;
    logic [3:0] div_busy_o;
    logic [3:0] tick_o;
    logic [3:0] sq_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] en;
        logic [3:0] tick;
        logic       sq3;
    } vec_t;

    vec_t tbl[12];

    rate_gen #(
        .NCH      (4),
        .CNT_W    (8),
        .DIV_INIT ({8'd4, 8'd3, 8'd2, 8'd1}),
        .SEL_W    (3)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .en_i       (en_i),
        .sync_i     (sync_i),
        .div_wr_i   (div_wr_i),
        .div_sel_i  (div_sel_i),
        .div_data_i (div_data_i),
        .div_busy_o (div_busy_o),
        .tick_o     (tick_o),
        .sq_o       (sq_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, exp, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic write_div(input int sel, input int data);
        div_wr_i   = 1'b1;
        div_sel_i  = 3'(sel);
        div_data_i = 8'(data);
        step();
        div_wr_i   = 1'b0;
    endtask

    task automatic do_reset();
        rst_i    = 1'b1;
        en_i     = 4'h0;
        sync_i   = 1'b0;
        div_wr_i = 1'b0;
        repeat (2) step();
        rst_i    = 1'b0;
    endtask

    // Steps until tick_o[ch] is seen; n = cycles taken (-1 on timeout),
    // busy_hi = samples before the tick where the channel reported busy.
    task automatic run_to_tick(input int ch, output int n, output int busy_hi);
        bit found = 1'b0;
        n = 0;
        busy_hi = 0;
        for (int i = 0; i < 300 && !found; i++) begin
            step();
            n++;
            if (tick_o[ch])
                found = 1'b1;
            else if (div_busy_o[ch])
                busy_hi++;
        end
        if (!found) n = -1;
    endtask

    initial begin
        int n, bh, cnt_t, first, c0, c1;
        logic exp_sq;

        tbl[0]  = '{4'hF, 4'b0001, 1'b0};
        tbl[1]  = '{4'hF, 4'b0011, 1'b0};
        tbl[2]  = '{4'hF, 4'b0101, 1'b0};
        tbl[3]  = '{4'hF, 4'b1011, 1'b1};
        tbl[4]  = '{4'hF, 4'b0001, 1'b1};
        tbl[5]  = '{4'hF, 4'b0111, 1'b1};
        tbl[6]  = '{4'hF, 4'b0001, 1'b1};
        tbl[7]  = '{4'hF, 4'b1011, 1'b0};
        tbl[8]  = '{4'hF, 4'b0101, 1'b0};
        tbl[9]  = '{4'hF, 4'b0011, 1'b0};
        tbl[10] = '{4'hF, 4'b0001, 1'b0};
        tbl[11] = '{4'hF, 4'b1111, 1'b1};

        div_sel_i  = 3'd0;
        div_data_i = 8'd0;

        // Reset state
        rst_i    = 1'b1;
        en_i     = 4'h0;
        sync_i   = 1'b0;
        div_wr_i = 1'b0;
        #2;
        chk("reset_tick", 32'(tick_o), 0);
        chk("reset_busy", 32'(div_busy_o), 0);
        chk("reset_sq", 32'(sq_o), 0);

        // Reset divisors 1/2/3/4, all enabled
        do_reset();
        for (int i = 0; i < 12; i++) begin
            en_i = tbl[i].en;
            step();
`ifdef RATE_GEN_SQUARE_EN
            exp_sq = tbl[i].sq3;
`else
            exp_sq = 1'b0;
`endif
            chk($sformatf("tbl_tick[%0d]", i), 32'(tick_o), 32'(tbl[i].tick));
            chk($sformatf("tbl_sq3[%0d]", i), 32'(sq_o[3]), 32'(exp_sq));
        end

        // Mid-period write: divisor 10, write 4 at cnt = 3
        do_reset();
        write_div(0, 10);
        chk("dis_write_busy", 32'(div_busy_o[0]), 0);
        en_i = 4'b0001;
        repeat (3) step();
        write_div(0, 4);
        chk("mid_busy_set", 32'(div_busy_o[0]), 1);
        run_to_tick(0, n, bh);
        chk("mid_old_period", n, 6);
        chk("mid_busy_held", bh, 5);
        chk("mid_busy_clear", 32'(div_busy_o[0]), 0);
        run_to_tick(0, n, bh);
        chk("mid_new_period_a", n, 4);
        run_to_tick(0, n, bh);
        chk("mid_new_period_b", n, 4);

        // Two writes to a busy channel: last wins
        write_div(0, 7);
        write_div(0, 5);
        chk("busy2_busy", 32'(div_busy_o[0]), 1);
        run_to_tick(0, n, bh);
        chk("busy2_finish_old", n, 2);
        run_to_tick(0, n, bh);
        chk("busy2_period_a", n, 5);
        run_to_tick(0, n, bh);
        chk("busy2_period_b", n, 5);

        // Write on the wrap edge loads directly; out-of-range select ignored
        repeat (4) step();
        write_div(0, 3);
        chk("wrapwr_tick", 32'(tick_o[0]), 1);
        chk("wrapwr_busy", 32'(div_busy_o[0]), 0);
        run_to_tick(0, n, bh);
        chk("wrapwr_period", n, 3);
        write_div(5, 9);
        chk("badsel_busy", 32'(div_busy_o), 0);
        run_to_tick(0, n, bh);
        chk("badsel_rest", n, 2);
        run_to_tick(0, n, bh);
        chk("badsel_period", n, 3);

        // Disable ch1 at cnt = 2 for 20 cycles, write while disabled
        do_reset();
        write_div(1, 8);
        en_i = 4'b0010;
        repeat (2) step();
        en_i = 4'b0000;
        cnt_t = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            cnt_t += int'(tick_o[1]);
        end
        write_div(1, 6);
        chk("dis_wr_busy", 32'(div_busy_o[1]), 0);
        cnt_t += int'(tick_o[1]);
        for (int i = 0; i < 9; i++) begin
            step();
            cnt_t += int'(tick_o[1]);
        end
        chk("dis_no_ticks", cnt_t, 0);
        en_i = 4'b0010;
        run_to_tick(1, n, bh);
        chk("dis_resume", n, 4);
        run_to_tick(1, n, bh);
        chk("dis_new_period", n, 6);
        write_div(1, 3);
        chk("dis_pend_busy", 32'(div_busy_o[1]), 1);
        en_i = 4'b0000;
        step();
        chk("dis_pend_apply", 32'(div_busy_o[1]), 0);
        en_i = 4'b0010;
        run_to_tick(1, n, bh);
        chk("dis_pend_period", n, 2);

        // sync_i with divisors 3/5/7
        do_reset();
        write_div(2, 7);
        en_i = 4'b0111;
        repeat (2) step();
        write_div(1, 5);
        chk("sync_pre_busy", 32'(div_busy_o[1]), 1);
        sync_i     = 1'b1;
        div_wr_i   = 1'b1;
        div_sel_i  = 3'd0;
        div_data_i = 8'd3;
        step();
        sync_i   = 1'b0;
        div_wr_i = 1'b0;
        chk("sync_no_tick", 32'(tick_o), 0);
        chk("sync_busy", 32'(div_busy_o), 0);
        chk("sync_sq", 32'(sq_o), 0);
        first = 0;
        c0 = 0;
        c1 = 0;
        for (int m = 1; m <= 105; m++) begin
            step();
            if (tick_o[2:0] == 3'b111 && first == 0) first = m;
            c0 += int'(tick_o[0]);
            c1 += int'(tick_o[1]);
        end
        chk("sync_coincide", first, 105);
        chk("sync_ch0_count", c0, 35);
        chk("sync_ch1_count", c1, 21);

        // Asynchronous reset mid-period
        #2;
        rst_i = 1'b1;
        #1;
        chk("arst_tick", 32'(tick_o), 0);
        chk("arst_busy", 32'(div_busy_o), 0);
        chk("arst_sq", 32'(sq_o), 0);
        en_i  = 4'hF;
        rst_i = 1'b0;
        run_to_tick(2, n, bh);
        chk("arst_div_init_a", n, 3);
        run_to_tick(2, n, bh);
        chk("arst_div_init_b", n, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
